// File: rtl/core_feeder_if.sv
// West/north word streams feeding core_feeder: the source drives data/valid,
// and the feeder drives ready.
interface core_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] s_w_data;
  logic             s_w_valid;
  logic             s_w_ready;
  logic [WIDTH-1:0] s_n_data;
  logic             s_n_valid;
  logic             s_n_ready;

  modport master (
    output s_w_data, s_w_valid, s_n_data, s_n_valid,
    input  s_w_ready, s_n_ready
  );

  modport slave (
    input  s_w_data, s_w_valid, s_n_data, s_n_valid,
    output s_w_ready, s_n_ready
  );
endinterface

// File: rtl/core_feeder.sv
// Collects CHUNK_SIZE-word chunks from two streams and presents them to a core for BLOCK_SIZE cycles.
// The optional accumulator watchdog is enabled by defining FEEDER_WATCHDOG_EN.
module core_feeder #(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 64,
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  core_feeder_if.slave                s,
  input  logic                        accumulator_done,
  output logic [WIDTH*CHUNK_SIZE-1:0] input_w,
  output logic [WIDTH*CHUNK_SIZE-1:0] input_n,
  output logic                        en,
  output logic                        reset_acc,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);
  localparam int NCHUNK = INNER_DIMENSION / BLOCK_SIZE;
  localparam int BUSW   = WIDTH * CHUNK_SIZE;
  localparam int CW     = $clog2(CHUNK_SIZE + 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FILL, ISSUE, WAIT_ACC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   w_cnt_q, w_cnt_d, n_cnt_q, n_cnt_d;
  logic [KW-1:0]   chunk_q, chunk_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [BUSW-1:0] w_bus_q, w_bus_d, n_bus_q, n_bus_d;
  logic            w_rdy_q, w_rdy_d, n_rdy_q, n_rdy_d;
  logic            en_q, en_d, reset_acc_q, reset_acc_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            w_fire, n_fire;

`ifdef FEEDER_WATCHDOG_EN
  localparam int WW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
`else
  // WATCHDOG_CYCLES has no effect in this build; referenced here only as a config guard.
  if (WATCHDOG_CYCLES < 1) begin : g_wd_cfg_unused
  end
`endif

  // Readies are only ever high in FILL, so a fire implies FILL.
  assign w_fire = s.s_w_valid && w_rdy_q;
  assign n_fire = s.s_n_valid && n_rdy_q;

  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    n_cnt_d = n_cnt_q;
    chunk_d = chunk_q;
    blk_d   = blk_q;
    w_bus_d = w_bus_q;
    n_bus_d = n_bus_q;
`ifdef FEEDER_WATCHDOG_EN
    wd_d      = '0;
    timeout_d = 1'b0;
`endif

    // Word k lands in slice k counted from the MSB end.
    for (int unsigned i = 0; i < CHUNK_SIZE; i++) begin
      if (w_fire && (w_cnt_q == CW'(i))) w_bus_d[BUSW-WIDTH*(i+1) +: WIDTH] = s.s_w_data;
      if (n_fire && (n_cnt_q == CW'(i))) n_bus_d[BUSW-WIDTH*(i+1) +: WIDTH] = s.s_n_data;
    end
    if (w_fire) w_cnt_d = w_cnt_q + CW'(1);
    if (n_fire) n_cnt_d = n_cnt_q + CW'(1);

    case (state_q)
      IDLE: if (start) state_d = CLEAR;
      CLEAR: begin
        w_cnt_d = '0;
        n_cnt_d = '0;
        chunk_d = '0;
        blk_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        if ((w_cnt_d == CW'(CHUNK_SIZE)) && (n_cnt_d == CW'(CHUNK_SIZE))) begin
          blk_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (blk_q == BW'(BLOCK_SIZE - 1)) begin
          blk_d   = '0;
          w_cnt_d = '0;
          n_cnt_d = '0;
          if (chunk_q == KW'(NCHUNK - 1)) begin
            state_d = WAIT_ACC;
          end else begin
            chunk_d = chunk_q + KW'(1);
            state_d = FILL;
          end
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      WAIT_ACC: begin
        if (accumulator_done) begin
          state_d = DONE;
`ifdef FEEDER_WATCHDOG_EN
        end else if (wd_q == WW'(WATCHDOG_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered as a function of the next state so they align with state_q.
    en_d        = (state_d == ISSUE);
    reset_acc_d = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    w_rdy_d     = (state_d == FILL) && (w_cnt_d < CW'(CHUNK_SIZE));
    n_rdy_d     = (state_d == FILL) && (n_cnt_d < CW'(CHUNK_SIZE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_cnt_q     <= '0;
      n_cnt_q     <= '0;
      chunk_q     <= '0;
      blk_q       <= '0;
      w_bus_q     <= '0;
      n_bus_q     <= '0;
      w_rdy_q     <= 1'b0;
      n_rdy_q     <= 1'b0;
      en_q        <= 1'b0;
      reset_acc_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      n_cnt_q     <= n_cnt_d;
      chunk_q     <= chunk_d;
      blk_q       <= blk_d;
      w_bus_q     <= w_bus_d;
      n_bus_q     <= n_bus_d;
      w_rdy_q     <= w_rdy_d;
      n_rdy_q     <= n_rdy_d;
      en_q        <= en_d;
      reset_acc_q <= reset_acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign s.s_w_ready = w_rdy_q;
  assign s.s_n_ready = n_rdy_q;
  assign input_w     = w_bus_q;
  assign input_n     = n_bus_q;
  assign en          = en_q;
  assign reset_acc   = reset_acc_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_core_feeder.sv
// Scoreboard bench for core_feeder: stream drivers push expected chunks, the en monitor pops them.
module tb_core_feeder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int BLOCK = 2;
  localparam int NCH   = 32;
  localparam int WD    = 16;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        accumulator_done = 1'b0;
  logic [63:0] input_w, input_n;
  logic        en, reset_acc, busy, done, timeout;

  core_feeder_if #(.WIDTH(WIDTH)) bus ();

  core_feeder #(
    .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .BLOCK_SIZE(BLOCK),
    .INNER_DIMENSION(64), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .s(bus),
    .accumulator_done(accumulator_done),
    .input_w(input_w), .input_n(input_n),
    .en(en), .reset_acc(reset_acc), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wordval(input int b, input int idx, input int off);
    return 16'(b + 8 * (idx / CHUNK) + (idx % CHUNK) + off);
  endfunction

  // Stream sources and scoreboard producers
  bit          w_on = 1'b1, n_on = 1'b1;
  int          w_idx = 0, n_idx = 0, base = 0;
  logic [63:0] w_acc = '0, n_acc = '0;
  logic [63:0] exp_w_q[$];
  logic [63:0] exp_n_q[$];

  initial begin
    bus.s_w_valid = 1'b0;
    bus.s_w_data  = '0;
    forever begin
      @(negedge clk); #1;
      if (w_on) begin
        bus.s_w_valid = 1'b1;
        bus.s_w_data  = wordval(base, w_idx, 1);
        if (bus.s_w_ready && !rst) begin
          w_acc = {w_acc[47:0], bus.s_w_data};
          w_idx++;
          if (w_idx % CHUNK == 0) exp_w_q.push_back(w_acc);
        end
      end else begin
        bus.s_w_valid = 1'b0;
      end
    end
  end

  initial begin
    bus.s_n_valid = 1'b0;
    bus.s_n_data  = '0;
    forever begin
      @(negedge clk); #1;
      if (n_on) begin
        bus.s_n_valid = 1'b1;
        bus.s_n_data  = wordval(base, n_idx, 5);
        if (bus.s_n_ready && !rst) begin
          n_acc = {n_acc[47:0], bus.s_n_data};
          n_idx++;
          if (n_idx % CHUNK == 0) exp_n_q.push_back(n_acc);
        end
      end else begin
        bus.s_n_valid = 1'b0;
      end
    end
  end

  // Consumer side: checks every issued chunk, en run length and chunk spacing
  bit          per_chk = 1'b0;
  bit          en_prev = 1'b0;
  int          run = 0, cyc = 0, last_rise = 0;
  int          chunks = 0, en_total = 0, ra_cnt = 0, done_cnt = 0, to_cnt = 0;
  logic [63:0] hold_w = '0, hold_n = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        en_prev = 1'b0;
        run = 0;
      end else begin
        if (en) begin
          if (!en_prev) begin
            if (per_chk && chunks > 0) check("chunk_period", 64'(cyc - last_rise), 64'd6);
            last_rise = cyc;
            chunks++;
            run = 0;
            if (exp_w_q.size() == 0 || exp_n_q.size() == 0) begin
              check("sb_nonempty", 64'(exp_w_q.size() > 0 && exp_n_q.size() > 0), 64'd1);
            end else begin
              hold_w = exp_w_q.pop_front();
              hold_n = exp_n_q.pop_front();
            end
          end
          check("input_w", input_w, hold_w);
          check("input_n", input_n, hold_n);
          run++;
          en_total++;
        end else if (en_prev) begin
          check("en_run", 64'(run), 64'(BLOCK));
        end
        if (reset_acc) ra_cnt++;
        if (done)      done_cnt++;
        if (timeout)   to_cnt++;
        en_prev = en;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    chunks = 0; en_total = 0; ra_cnt = 0; done_cnt = 0; to_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tile_end(input string tag);
    int n = 0;
    while (!(en_total == 2 * NCH && !en) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < LIMIT), 64'd1);
  endtask

  initial begin
    int n;
    int w0;

    repeat (3) @(negedge clk);
    check("rst_en", 64'(en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_w_ready", 64'(bus.s_w_ready), 64'd0);
    check("rst_input_w", input_w, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Tile 1: both streams continuously valid
    per_chk = 1'b1;
    pulse_start();
    check("clear_reset_acc", 64'(reset_acc), 64'd1);
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_en", 64'(en), 64'd0);
    @(negedge clk);
    check("fill_reset_acc", 64'(reset_acc), 64'd0);
    check("fill_w_ready", 64'(bus.s_w_ready), 64'd1);
    check("fill_n_ready", 64'(bus.s_n_ready), 64'd1);
    n = 2;
    while (!en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("first_en_latency", 64'(n), 64'd6);
    check("chunk0_w", input_w, 64'h0001_0002_0003_0004);
    check("chunk0_n", input_n, 64'h0005_0006_0007_0008);

    // Spurious start in FILL and accumulator_done in ISSUE must be ignored
    n = 0;
    while (!(chunks == 3 && !en && busy) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach_fill3", 64'(n < LIMIT), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!en && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    accumulator_done = 1'b1;
    @(negedge clk);
    accumulator_done = 1'b0;

    wait_tile_end("tile1_end");
    check("t1_chunks", 64'(chunks), 64'(NCH));
    check("t1_en_cycles", 64'(en_total), 64'(2 * NCH));
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_w_ready", 64'(bus.s_w_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("wait_no_done", 64'(done), 64'd0);
    accumulator_done = 1'b1;
    @(negedge clk);
    accumulator_done = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("done_low", 64'(done), 64'd0);
    check("idle_busy_after", 64'(busy), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_reset_acc_cnt", 64'(ra_cnt), 64'd1);

    // Tile 2: reset after two west words of chunk 5
    per_chk = 1'b0;
    w0 = w_idx;
    pulse_start();
    n = 0;
    while (w_idx != w0 + 22 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach_chunk5", 64'(n < LIMIT), 64'd1);
    rst = 1'b1;
    #2;
    check("arst_en", 64'(en), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_reset_acc", 64'(reset_acc), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_timeout", 64'(timeout), 64'd0);
    check("arst_w_ready", 64'(bus.s_w_ready), 64'd0);
    check("arst_n_ready", 64'(bus.s_n_ready), 64'd0);
    check("arst_input_w", input_w, 64'd0);
    check("arst_input_n", input_n, 64'd0);
    exp_w_q.delete();
    exp_n_q.delete();
    w_idx = 0; n_idx = 0; w_acc = '0; n_acc = '0;
    base = 100;
    n_on = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t2_no_done", 64'(done_cnt), 64'd0);

    // Tile 3: north held off 10 cycles after west completes, then watchdog behaviour
    pulse_start();
    check("t3_reset_acc", 64'(reset_acc), 64'd1);
    n = 0;
    while (w_idx < 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t3_west_full", 64'(n < LIMIT), 64'd1);
    check("t3_w_ready_low", 64'(bus.s_w_ready), 64'd0);
    check("t3_n_ready_high", 64'(bus.s_n_ready), 64'd1);
    repeat (10) @(negedge clk);
    check("t3_no_issue_yet", 64'(en), 64'd0);
    n_on = 1'b1;
    n = 0;
    while (n_idx < 4 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("t3_north_full", 64'(n < LIMIT), 64'd1);
    check("t3_issue_next", 64'(en), 64'd1);
    check("t3_chunk0_w", input_w, 64'h0065_0066_0067_0068);
    check("t3_chunk0_n", input_n, 64'h0069_006a_006b_006c);

    wait_tile_end("tile3_end");
    check("t3_chunks", 64'(chunks), 64'(NCH));
`ifdef FEEDER_WATCHDOG_EN
    repeat (15) @(negedge clk);
    check("wd_pre_timeout", 64'(timeout), 64'd0);
    check("wd_pre_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("wd_timeout", 64'(timeout), 64'd1);
    check("wd_idle", 64'(busy), 64'd0);
    check("wd_no_done", 64'(done), 64'd0);
    @(negedge clk);
    check("wd_timeout_pulse", 64'(timeout), 64'd0);
    check("wd_to_cnt", 64'(to_cnt), 64'd1);
    check("wd_done_cnt", 64'(done_cnt), 64'd0);
`else
    repeat (40) @(negedge clk);
    check("nowd_busy", 64'(busy), 64'd1);
    check("nowd_timeout", 64'(timeout), 64'd0);
    check("nowd_no_done", 64'(done_cnt), 64'd0);
    accumulator_done = 1'b1;
    @(negedge clk);
    accumulator_done = 1'b0;
    check("t3_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("t3_idle", 64'(busy), 64'd0);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);
    check("t3_to_cnt", 64'(to_cnt), 64'd0);
`endif
    check("sb_drain_w", 64'(exp_w_q.size()), 64'd0);
    check("sb_drain_n", 64'(exp_n_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit exceeded");
  end
endmodule

// File: doc/core_feeder.md
CORE_FEEDER -- requirements
Module: core_feeder

Interface
REQ-001 Parameter WIDTH, default 16: bits per fixed-point word.
REQ-002 Parameter CHUNK_SIZE, default 4: words per chunk on each of the west and north buses.
REQ-003 Parameter BLOCK_SIZE, default 2: cycles each chunk is held on the core inputs with en high.
REQ-004 Parameter INNER_DIMENSION, default 64: inner dimension; chunks per tile NCHUNK = INNER_DIMENSION/BLOCK_SIZE (32 at defaults).
REQ-005 Parameter WATCHDOG_CYCLES, default 256: accumulator_done timeout, used only with FEEDER_WATCHDOG_EN.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  begin one tile; sampled only in IDLE.
REQ-009 s_w_data  input  WIDTH  west word stream; s_w_valid input 1; s_w_ready output 1.
REQ-010 s_n_data  input  WIDTH  north word stream; s_n_valid input 1; s_n_ready output 1.
REQ-011 accumulator_done  input  1  from core; tile accumulation complete.
REQ-012 input_w, input_n  output  WIDTH*CHUNK_SIZE  chunk buses to core.
REQ-013 en, reset_acc  output  1 each  core enable and accumulator clear.
REQ-014 busy  output  1  high in every state except IDLE; done  output  1  one-cycle tile-complete pulse.
REQ-015 timeout  output  1  one-cycle watchdog pulse (constant 0 without FEEDER_WATCHDOG_EN).

Function
REQ-016 FSM states: IDLE, CLEAR, FILL, ISSUE, WAIT_ACC, DONE; all outputs registered.
REQ-017 IDLE: start=1 -> CLEAR next cycle; start in any other state is ignored.
REQ-018 CLEAR: reset_acc=1 for exactly one cycle, chunk counter and both word counters zeroed -> FILL.
REQ-019 FILL: s_w_ready=1 while west word count < CHUNK_SIZE; s_n_ready likewise, each side independent.
REQ-020 A word is accepted only on valid&&ready; the k-th accepted word (k=0 first) of a side is written to bits [WIDTH*(CHUNK_SIZE-k)-1 : WIDTH*(CHUNK_SIZE-k-1)] of that side's bus, so word 0 occupies the MSB slice.
REQ-021 Both sides holding CHUNK_SIZE words -> ISSUE next cycle; both readies low outside FILL.
REQ-022 ISSUE: en=1 for exactly BLOCK_SIZE consecutive cycles; input_w/input_n stable throughout; en=0 in all other states.
REQ-023 ISSUE end: word counters cleared; chunk counter < NCHUNK-1 -> increment and FILL; chunk counter = NCHUNK-1 -> WAIT_ACC.
REQ-024 WAIT_ACC: accumulator_done=1 -> DONE; DONE asserts done for one cycle -> IDLE.
REQ-025 accumulator_done outside WAIT_ACC is ignored.
REQ-026 input_w/input_n retain their last chunk in IDLE, WAIT_ACC, and DONE.
REQ-027 Minimum chunk period with both streams continuously valid: CHUNK_SIZE+BLOCK_SIZE cycles (6 at defaults).

Reset
REQ-028 rst=1 asynchronously forces IDLE; clears all counters; sets en, reset_acc, busy, done, timeout, s_w_ready, s_n_ready, input_w, input_n to 0.
REQ-029 Reset mid-tile discards partial chunks; no done is issued for that tile.

Configuration
REQ-030 Macro FEEDER_WATCHDOG_EN defined: WAIT_ACC counts cycles; after WATCHDOG_CYCLES cycles without accumulator_done, timeout=1 for one cycle, state -> IDLE, no done.
REQ-031 accumulator_done arriving in the same cycle the watchdog expires: done wins, no timeout.
REQ-032 FEEDER_WATCHDOG_EN undefined: WAIT_ACC waits indefinitely; no watchdog counter; timeout tied 0.

Verification
REQ-033 rst, then start; both streams valid every cycle, west words 1..4, north 5..8 -> reset_acc one cycle; input_w=0x0001_0002_0003_0004, input_n=0x0005_0006_0007_0008; en high 2 cycles.
REQ-034 Full tile at defaults, streams always valid -> 32 ISSUE phases (64 en cycles); accumulator_done 3 cycles after WAIT_ACC entry -> one done pulse; busy falls with return to IDLE.
REQ-035 North valid delayed 10 cycles after west complete -> s_w_ready low after 4th west word; ISSUE entered the cycle after the 4th north word.
REQ-036 rst asserted after 2 west words of chunk 5 -> all outputs 0 immediately; next start produces reset_acc and chunk 0 with fresh words.
REQ-037 FEEDER_WATCHDOG_EN, WATCHDOG_CYCLES=16, accumulator_done never driven -> timeout pulse 16 cycles after WAIT_ACC entry, no done; without macro, busy stays high.
REQ-038 start pulsed during FILL and accumulator_done pulsed during ISSUE -> no state change, counters unaffected.
